// File: rtl/rvv_backend_pkg.sv
// rvv_backend_pkg: shared retire-path types for the vector backend.
// Provides the retire group size, vector width, the retire-entry struct,
// the VRF write-slot struct and the write-scheduler state enum.
package rvv_backend_pkg;
    localparam int PKG_NUM_RT_UOP = 4;
    localparam int PKG_VLEN       = 128;

    typedef enum logic {IDLE, DRAIN} wr_state_e;

    typedef struct packed {
        logic [4:0]            index;
        logic [PKG_VLEN-1:0]   data;
        logic [PKG_VLEN/8-1:0] strobe;
        logic                  vxsat;
    } rt_uop_t;

    typedef struct packed {
        logic [4:0]            index;
        logic [PKG_VLEN-1:0]   data;
        logic [PKG_VLEN/8-1:0] strobe;
    } wr_slot_t;
endpackage

// File: rtl/rvv_rt_vrf_wr_sched_merge.sv
// rvv_rt_wr_merge: combinational same-index merge of one retire group.
// Ports: valid/ent  - retire entries in program order
//        slot/pend  - merged write slots; only the oldest entry of each index stays pending
// Each merged slot ORs the strobes and takes every byte from the youngest enabling entry.
module rvv_rt_wr_merge
    import rvv_backend_pkg::*;
#(
    parameter int NUM_RT_UOP = PKG_NUM_RT_UOP
) (
    input  logic     [NUM_RT_UOP-1:0] valid,
    input  wr_slot_t [NUM_RT_UOP-1:0] ent,
    output wr_slot_t [NUM_RT_UOP-1:0] slot,
    output logic     [NUM_RT_UOP-1:0] pend
);
    always_comb begin
        slot = ent;
        pend = valid;
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            for (int j = 0; j < i; j++)
                if (valid[j] && ent[j].index == ent[i].index) pend[i] = 1'b0;
            // later entries overwrite, so the youngest enabling entry wins each byte
            for (int j = i + 1; j < NUM_RT_UOP; j++)
                if (valid[j] && ent[j].index == ent[i].index) begin
                    slot[i].strobe = slot[i].strobe | ent[j].strobe;
                    for (int b = 0; b < PKG_VLEN/8; b++)
                        if (ent[j].strobe[b]) slot[i].data[8*b +: 8] = ent[j].data[8*b +: 8];
                end
        end
    end
endmodule

// File: rtl/rvv_rt_vrf_wr_sched.sv
// rvv_rt_vrf_wr_sched: buffers one retire group and drains it onto the VRF write ports.
// Ports: clk, rst_n (sync, active-low); rt_* retire group in, rt_ready accept;
//        flush trap flush; vrf_wr_* up to NUM_WR_PORT writes per cycle, oldest first;
//        wr_vxsat_valid/wr_vxsat one pulse with the first write cycle of each group.
// Option: define RVV_RT_WR_MERGE_EN to merge same-index entries at capture.
module rvv_rt_vrf_wr_sched
    import rvv_backend_pkg::*;
#(
    parameter int NUM_RT_UOP  = PKG_NUM_RT_UOP,
    parameter int NUM_WR_PORT = 2,
    parameter int VLEN        = PKG_VLEN
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_RT_UOP-1:0]                rt_valid,
    input  logic [NUM_RT_UOP-1:0][4:0]           rt_index,
    input  logic [NUM_RT_UOP-1:0][VLEN-1:0]      rt_data,
    input  logic [NUM_RT_UOP-1:0][VLEN/8-1:0]    rt_strobe,
    input  logic [NUM_RT_UOP-1:0]                rt_vxsat,
    output logic                                 rt_ready,
    input  logic                                 flush,
    output logic [NUM_WR_PORT-1:0]               vrf_wr_valid,
    output logic [NUM_WR_PORT-1:0][4:0]          vrf_wr_index,
    output logic [NUM_WR_PORT-1:0][VLEN-1:0]     vrf_wr_data,
    output logic [NUM_WR_PORT-1:0][VLEN/8-1:0]   vrf_wr_strobe,
    output logic                                 wr_vxsat_valid,
    output logic                                 wr_vxsat
);
    wr_state_e                  state;
    rt_uop_t  [NUM_RT_UOP-1:0]  ent;
    wr_slot_t [NUM_RT_UOP-1:0]  ent_s, cap_slot, slot_q;
    logic     [NUM_RT_UOP-1:0]  cap_pend, pend_q, iss;
    logic     [NUM_WR_PORT-1:0] wv;
    logic                       cap_vx, vx_q, first_q, last, acc, live;

    always_comb begin
        cap_vx = 1'b0;
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            ent[i]   = '{index: rt_index[i], data: rt_data[i], strobe: rt_strobe[i], vxsat: rt_vxsat[i]};
            ent_s[i] = '{index: ent[i].index, data: ent[i].data, strobe: ent[i].strobe};
            cap_vx   = cap_vx | (rt_valid[i] & ent[i].vxsat);
        end
    end

`ifdef RVV_RT_WR_MERGE_EN
    rvv_rt_wr_merge #(.NUM_RT_UOP(NUM_RT_UOP)) u_merge (
        .valid (rt_valid),
        .ent   (ent_s),
        .slot  (cap_slot),
        .pend  (cap_pend)
    );
`else
    assign cap_slot = ent_s;
    assign cap_pend = rt_valid;
`endif

    // Walk pending slots oldest first; stop at a full port set or at an index
    // already picked this cycle so same-vreg writes keep program order.
    always_comb begin
        int   n;
        logic stop;
        n             = 0;
        stop          = 1'b0;
        iss           = '0;
        wv            = '0;
        vrf_wr_index  = '0;
        vrf_wr_data   = '0;
        vrf_wr_strobe = '0;
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            if (pend_q[i] && !stop) begin
                stop = (n == NUM_WR_PORT);
                for (int p = 0; p < NUM_WR_PORT; p++)
                    if (p < n && vrf_wr_index[p] == slot_q[i].index) stop = 1'b1;
                if (!stop) begin
                    wv[n]            = 1'b1;
                    vrf_wr_index[n]  = slot_q[i].index;
                    vrf_wr_data[n]   = slot_q[i].data;
                    vrf_wr_strobe[n] = slot_q[i].strobe;
                    iss[i]           = 1'b1;
                    n                = n + 1;
                end
            end
        end
    end

    assign live           = rst_n && !flush;
    assign last           = (pend_q & ~iss) == '0;
    assign rt_ready       = live && (state == IDLE || last);
    assign acc            = rt_ready && |rt_valid;
    assign vrf_wr_valid   = wv & {NUM_WR_PORT{live}};
    assign wr_vxsat_valid = live && first_q;
    assign wr_vxsat       = wr_vxsat_valid && vx_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state   <= IDLE;
            pend_q  <= '0;
            first_q <= 1'b0;
            vx_q    <= 1'b0;
        end else if (acc) begin
            state   <= DRAIN;
            slot_q  <= cap_slot;
            pend_q  <= cap_pend;
            first_q <= 1'b1;
            vx_q    <= cap_vx;
        end else begin
            pend_q  <= pend_q & ~iss;
            first_q <= 1'b0;
            if (state == DRAIN && last) state <= IDLE;
        end
    end
endmodule

// File: tb/tb_rvv_rt_vrf_wr_sched.sv
// tb_rvv_rt_vrf_wr_sched: scoreboard bench with a write-list reference model.
module tb_rvv_rt_vrf_wr_sched;
    localparam int N  = 4;
    localparam int P  = 2;
    localparam int VL = 128;
    localparam int SB = VL/8;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    flush = 1'b0;
    logic [N-1:0]            rt_valid = '0;
    logic [N-1:0]            rt_vxsat = '0;
    logic [N-1:0][4:0]       rt_index = '0;
    logic [N-1:0][VL-1:0]    rt_data = '0;
    logic [N-1:0][SB-1:0]    rt_strobe = '0;
    logic                    rt_ready, wr_vxsat_valid, wr_vxsat;
    logic [P-1:0]            vrf_wr_valid;
    logic [P-1:0][4:0]       vrf_wr_index;
    logic [P-1:0][VL-1:0]    vrf_wr_data;
    logic [P-1:0][SB-1:0]    vrf_wr_strobe;

    rvv_rt_vrf_wr_sched #(.NUM_RT_UOP(N), .NUM_WR_PORT(P), .VLEN(VL)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rt_valid       (rt_valid),
        .rt_index       (rt_index),
        .rt_data        (rt_data),
        .rt_strobe      (rt_strobe),
        .rt_vxsat       (rt_vxsat),
        .rt_ready       (rt_ready),
        .flush          (flush),
        .vrf_wr_valid   (vrf_wr_valid),
        .vrf_wr_index   (vrf_wr_index),
        .vrf_wr_data    (vrf_wr_data),
        .vrf_wr_strobe  (vrf_wr_strobe),
        .wr_vxsat_valid (wr_vxsat_valid),
        .wr_vxsat       (wr_vxsat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                   cyc;
        logic [P-1:0]         v;
        logic [P-1:0][4:0]    idx;
        logic [P-1:0][VL-1:0] dat;
        logic [P-1:0][SB-1:0] stb;
        logic                 vxv;
        logic                 vx;
    } beat_t;

    beat_t q[$];
    beat_t me;
    int cyc = 0, busy = -1, errs = 0, checks = 0;
    logic [N-1:0][4:0]    g_idx = '0;
    logic [N-1:0][VL-1:0] g_dat = '0;
    logic [N-1:0][SB-1:0] g_stb = '0;
    logic [N-1:0]         g_vx  = '0;

    task automatic chk(input string nm, input logic [VL-1:0] got, input logic [VL-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    // Reference: the group becomes an ordered write list (merged by index when the
    // option is on), then is cut into beats of at most P writes with no repeated vreg.
    task automatic accept_group(input logic [N-1:0] v);
        logic [4:0]    wi[$];
        logic [VL-1:0] wd[$];
        logic [SB-1:0] ws[$];
        logic [VL-1:0] t;
        beat_t b;
        int c, pos, n;
        bit hit, vx;
        vx = |(g_vx & v);
        for (int i = 0; i < N; i++) if (v[i]) begin
            hit = 0;
`ifdef RVV_RT_WR_MERGE_EN
            for (int k = 0; k < wi.size(); k++) if (wi[k] == g_idx[i]) begin
                hit = 1;
                t = wd[k];
                for (int y = 0; y < SB; y++) if (g_stb[i][y]) t[8*y +: 8] = g_dat[i][8*y +: 8];
                wd[k] = t;
                ws[k] = ws[k] | g_stb[i];
            end
`endif
            if (!hit) begin
                wi.push_back(g_idx[i]);
                wd.push_back(g_dat[i]);
                ws.push_back(g_stb[i]);
            end
        end
        c = cyc + 1;
        pos = 0;
        while (pos < wi.size()) begin
            b.cyc = c; b.v = '0; b.idx = '0; b.dat = '0; b.stb = '0;
            n = 0;
            hit = 0;
            while (pos < wi.size() && n < P && !hit) begin
                for (int p = 0; p < n; p++) if (b.idx[p] == wi[pos]) hit = 1;
                if (!hit) begin
                    b.v[n] = 1'b1; b.idx[n] = wi[pos]; b.dat[n] = wd[pos]; b.stb[n] = ws[pos];
                    n++;
                    pos++;
                end
            end
            b.vxv = (c == cyc + 1);
            b.vx  = b.vxv && vx;
            q.push_back(b);
            c++;
        end
        busy = c - 1;
    endtask

    task automatic step(input logic rn, input logic fl, input logic [N-1:0] v);
        bit rdy;
        @(negedge clk);
        cyc++;
        rst_n = rn; flush = fl; rt_valid = v;
        rt_index = g_idx; rt_data = g_dat; rt_strobe = g_stb; rt_vxsat = g_vx;
        rdy = rn && !fl && cyc >= busy;
        if (!rn || fl) begin
            while (q.size() > 0 && q[q.size()-1].cyc >= cyc) void'(q.pop_back());
            busy = cyc;
        end else if (rdy && v != '0) accept_group(v);
        #1 chk("rt_ready", VL'(rt_ready), VL'(rdy));
    endtask

    task automatic rand_group(input int maxidx);
        for (int i = 0; i < N; i++) begin
            g_idx[i] = 5'($urandom_range(0, maxidx));
            g_dat[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            g_stb[i] = ($urandom_range(0, 7) == 0) ? '0 : SB'($urandom());
            g_vx[i]  = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic distinct_group(input int base);
        rand_group(31);
        for (int i = 0; i < N; i++) g_idx[i] = 5'((base + i) % 32);
    endtask

    initial forever begin
        logic [VL-1:0] m;
        @(negedge clk);
        #2;
        if (q.size() > 0 && q[0].cyc == cyc) me = q.pop_front();
        else begin
            me.cyc = cyc; me.v = '0; me.idx = '0; me.dat = '0; me.stb = '0; me.vxv = 0; me.vx = 0;
        end
        chk("wr_valid", VL'(vrf_wr_valid), VL'(me.v));
        chk("vxsat_valid", VL'(wr_vxsat_valid), VL'(me.vxv));
        chk("vxsat", VL'(wr_vxsat), VL'(me.vx));
        for (int p = 0; p < P; p++) if (me.v[p]) begin
            for (int y = 0; y < SB; y++) m[8*y +: 8] = {8{me.stb[p][y]}};
            chk($sformatf("wr_index[%0d]", p), VL'(vrf_wr_index[p]), VL'(me.idx[p]));
            chk($sformatf("wr_strobe[%0d]", p), VL'(vrf_wr_strobe[p]), VL'(me.stb[p]));
            chk($sformatf("wr_data[%0d]", p), vrf_wr_data[p] & m, me.dat[p] & m);
        end
    end

    initial begin
        int r, n;
        repeat (3) step(0, 0, '0);
        // four distinct vregs 1..4: {1,2} then {3,4}, ready on the final drain cycle
        distinct_group(1);
        step(1, 0, 4'hf);
        repeat (3) step(1, 0, '0);
        // two entries to v5 with overlapping strobes
        g_idx[0] = 5'd5; g_stb[0] = 16'h00ff; g_dat[0] = {16{8'haa}}; g_vx[0] = 1'b1;
        g_idx[1] = 5'd5; g_stb[1] = 16'h0f0f; g_dat[1] = {16{8'hbb}}; g_vx[1] = 1'b0;
        step(1, 0, 4'b0011);
        repeat (3) step(1, 0, '0);
        // back-to-back groups, a new one offered every cycle
        for (int k = 0; k < 10; k++) begin
            distinct_group(4 * k);
            step(1, 0, 4'hf);
        end
        repeat (3) step(1, 0, '0);
        // flush on the first drain cycle, with a new group offered alongside
        distinct_group(9);
        step(1, 0, 4'hf);
        distinct_group(20);
        step(1, 1, 4'hf);
        repeat (2) step(1, 0, '0);
        // reset in the middle of a drain
        distinct_group(12);
        step(1, 0, 4'hf);
        step(0, 0, '0);
        step(0, 0, 4'hf);
        repeat (2) step(1, 0, '0);
        // random traffic with colliding indices, zero strobes, flushes and resets
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            n = $urandom_range(0, N);
            rand_group(7);
            step(r != 0, r == 1 || r == 2, N'((1 << n) - 1));
        end
        repeat (6) step(1, 0, '0);
        @(negedge clk);
        #3;
        chk("queue_empty", VL'(q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
